// File: rtl/switch_debounce.sv
// switch_debounce: push-button conditioner.
// The raw switch goes through a two-flop synchronizer, then a four-state FSM
// accepts a level change only after the synchronized input has been stable
// long enough. The FSM emits one-cycle press, release and long-press pulses,
// and keeps an 8-bit count of accepted presses.
// There is no valid/ready handshake. Every pulse output is a registered,
// single-cycle strobe. At most one of the three pulses is high in any cycle.
// o_State exposes the FSM state register for observation:
// 0 = RELEASED, 1 = PRESS_WAIT, 2 = PRESSED, 3 = RELEASE_WAIT.
module switch_debounce #(
    parameter int DEBOUNCE_CYCLES   = 250000,
    parameter int LONG_PRESS_CYCLES = 25000000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Switch,
    output logic       o_Switch,
    output logic       o_Press,
    output logic       o_Release,
    output logic       o_Long_Press,
    output logic [7:0] o_Press_Count,
    output logic [1:0] o_State
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int HW = $clog2(LONG_PRESS_CYCLES);

    // Terminal counts; both counters stop here, so neither can overflow.
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic            s1;
    logic            s2;
    logic [DW-1:0]   deb_cnt_q;
    logic [DW-1:0]   deb_cnt_d;
    logic [HW-1:0]   hold_cnt_q;
    logic [HW-1:0]   hold_cnt_d;
    logic            long_done_q;
    logic            long_done_d;
    logic            switch_d;
    logic            press_d;
    logic            release_d;
    logic            long_d;
    logic [7:0]      count_d;

    assign o_State = state_q;

    // Two-flop synchronizer for the asynchronous switch; only s2 reaches the FSM.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= i_Switch;
            s2 <= s1;
        end
    end

    // State, counters and all outputs register here; reset discards any progress.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_q       <= RELEASED;
            deb_cnt_q     <= '0;
            hold_cnt_q    <= '0;
            long_done_q   <= 1'b0;
            o_Switch      <= 1'b0;
            o_Press       <= 1'b0;
            o_Release     <= 1'b0;
            o_Long_Press  <= 1'b0;
            o_Press_Count <= 8'd0;
        end else begin
            state_q       <= state_d;
            deb_cnt_q     <= deb_cnt_d;
            hold_cnt_q    <= hold_cnt_d;
            long_done_q   <= long_done_d;
            o_Switch      <= switch_d;
            o_Press       <= press_d;
            o_Release     <= release_d;
            o_Long_Press  <= long_d;
            o_Press_Count <= count_d;
        end
    end

    // Next-state, counter and output decode from the synchronized switch level.
    always_comb begin
        state_d     = state_q;
        deb_cnt_d   = deb_cnt_q;
        hold_cnt_d  = hold_cnt_q;
        long_done_d = long_done_q;
        switch_d    = o_Switch;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        count_d     = o_Press_Count;

        case (state_q)
            RELEASED: begin
                if (s2) begin
                    state_d   = PRESS_WAIT;
                    deb_cnt_d = '0;
                end
            end

            PRESS_WAIT: begin
                if (!s2) begin
                    // The input bounced back before it was stable: drop it silently.
                    state_d = RELEASED;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d     = PRESSED;
                    switch_d    = 1'b1;
                    press_d     = 1'b1;
                    count_d     = o_Press_Count + 8'd1;
                    hold_cnt_d  = '0;
                    long_done_d = 1'b0;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end

            PRESSED: begin
                if (!s2) begin
                    state_d   = RELEASE_WAIT;
                    deb_cnt_d = '0;
                end else begin
                    if (hold_cnt_q != HOLD_LAST) begin
                        hold_cnt_d = hold_cnt_q + HW'(1);
                    end
                    // long_done limits the long-press pulse to one per accepted press.
                    if (hold_cnt_q == HOLD_LAST && !long_done_q) begin
                        long_d      = 1'b1;
                        long_done_d = 1'b1;
                    end
                end
            end

            RELEASE_WAIT: begin
                if (s2) begin
                    // A short glitch low: resume the press. hold_cnt and
                    // long_done were frozen, so long-press timing continues.
                    state_d = PRESSED;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = RELEASED;
                    switch_d  = 1'b0;
                    release_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end

            default: begin
                state_d = RELEASED;
            end
        endcase
    end

endmodule

// File: tb/tb_switch_debounce.sv
// Testbench for switch_debounce with DEBOUNCE_CYCLES=4 and LONG_PRESS_CYCLES=10.
// The reference model describes debouncing in terms of run lengths.
// A level change is accepted once the synchronized input has disagreed with
// the accepted level for DEBOUNCE_CYCLES+1 consecutive samples.
// The long press fires on the LONG_PRESS_CYCLES-th uninterrupted "still
// pressed" sample.
module tb_switch_debounce;

    localparam int D = 4;
    localparam int L = 10;

    logic       clk;
    logic       rst_l;
    logic       sw;
    logic       o_switch;
    logic       o_press;
    logic       o_release;
    logic       o_long;
    logic [7:0] o_count;
    logic [1:0] o_state;

    int n_checks = 0;
    int n_errors = 0;

    switch_debounce #(
        .DEBOUNCE_CYCLES  (D),
        .LONG_PRESS_CYCLES(L)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_l),
        .i_Switch     (sw),
        .o_Switch     (o_switch),
        .o_Press      (o_press),
        .o_Release    (o_release),
        .o_Long_Press (o_long),
        .o_Press_Count(o_count),
        .o_State      (o_state)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single checking task.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state, updated on every rising edge.
    logic       sync0, sync1, seen;
    logic       m_level;
    int         m_run;
    int         m_held;
    logic       m_long_fired;
    logic       m_press, m_rel, m_long;
    logic [7:0] m_count;
    logic [7:0] exp_q[$];

    always @(posedge clk) begin
        if (!rst_l) begin
            sync0 = 1'b0; sync1 = 1'b0;
            m_level = 1'b0; m_run = 0; m_held = 0; m_long_fired = 1'b0;
            m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0; m_count = 8'd0;
            exp_q.delete();
        end else begin
            seen  = sync1;
            sync1 = sync0;
            sync0 = sw;
            m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
            if (seen != m_level) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_level = seen;
                    m_run   = 0;
                    if (seen) begin
                        m_press = 1'b1;
                        m_count = m_count + 8'd1;
                        m_held = 0;
                        m_long_fired = 1'b0;
                        exp_q.push_back(m_count);
                    end else begin
                        m_rel = 1'b1;
                    end
                end
            end else begin
                if (m_level && m_run == 0) begin
                    if (m_held < L) m_held++;
                    if (m_held == L && !m_long_fired) begin
                        m_long = 1'b1;
                        m_long_fired = 1'b1;
                    end
                end
                m_run = 0;
            end
        end
    end

    // Scoreboard: per-cycle comparison on the falling edge, plus pulse tallies.
    logic chk_en = 1'b0;
    int   n_press_seen = 0;
    int   n_rel_seen = 0;
    int   n_long_seen = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("switch", 32'(o_switch), 32'(m_level));
            check("press", 32'(o_press), 32'(m_press));
            check("release", 32'(o_release), 32'(m_rel));
            check("long", 32'(o_long), 32'(m_long));
            check("count", 32'(o_count), 32'(m_count));
            check("exclusive", 32'((32'(o_press) + 32'(o_release) + 32'(o_long)) <= 1), 32'd1);
            if (o_press === 1'b1) begin
                n_press_seen++;
                check("press_q_len", 32'(exp_q.size()), 32'd1);
                if (exp_q.size() > 0) check("press_q_count", 32'(o_count), 32'(exp_q.pop_front()));
            end
            if (o_release === 1'b1) n_rel_seen++;
            if (o_long === 1'b1) n_long_seen++;
        end
    end

    // Driver tasks.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Watch up to max_edges edges; report the index of the first pulse of each kind, or -1.
    task automatic watch(input int max_edges, output int press_at, output int long_at, output int rel_at);
        press_at = -1; long_at = -1; rel_at = -1;
        for (int n = 0; n < max_edges; n++) begin
            @(posedge clk);
            #1;
            if (o_press === 1'b1 && press_at < 0) press_at = n;
            if (o_long === 1'b1 && long_at < 0) long_at = n;
            if (o_release === 1'b1 && rel_at < 0) rel_at = n;
        end
    endtask

    task automatic do_reset(input int n);
        rst_l = 1'b0;
        tick(n);
        rst_l = 1'b1;
    endtask

    int p_at, l_at, r_at;
    int p0, r0, l0;
    logic [7:0] cnt0;

    initial begin
        rst_l = 1'b0;
        sw    = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        tick(2);
        check("rst_switch", 32'(o_switch), 32'd0);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_state", 32'(o_state), 32'd0);
        rst_l = 1'b1;
        tick(3);

        // Clean press held 30 cycles, then release.
        sw = 1'b1;
        watch(30, p_at, l_at, r_at);
        check("clean_press_edge", 32'(p_at), 32'd6);
        check("clean_long_edge", 32'(l_at), 32'd16);
        check("clean_count", 32'(o_count), 32'd1);
        check("clean_switch", 32'(o_switch), 32'd1);
        sw = 1'b0;
        watch(16, p_at, l_at, r_at);
        check("release_edge", 32'(r_at), 32'd6);
        check("release_switch", 32'(o_switch), 32'd0);

        // Bounce: three high cycles must not be accepted.
        p0 = n_press_seen; r0 = n_rel_seen; l0 = n_long_seen; cnt0 = o_count;
        sw = 1'b1;
        tick(3);
        sw = 1'b0;
        tick(15);
        check("bounce_pulses", 32'(n_press_seen - p0 + n_rel_seen - r0 + n_long_seen - l0), 32'd0);
        check("bounce_switch", 32'(o_switch), 32'd0);
        check("bounce_count", 32'(o_count), 32'(cnt0));

        // Two-cycle low glitch while pressed.
        p0 = n_press_seen; r0 = n_rel_seen; l0 = n_long_seen; cnt0 = o_count;
        sw = 1'b1;
        tick(10);
        sw = 1'b0;
        tick(2);
        sw = 1'b1;
        tick(30);
        check("glitch_press", 32'(n_press_seen - p0), 32'd1);
        check("glitch_release", 32'(n_rel_seen - r0), 32'd0);
        check("glitch_long", 32'(n_long_seen - l0), 32'd1);
        check("glitch_count", 32'(o_count), 32'(cnt0 + 8'd1));
        sw = 1'b0;
        tick(15);

        // Random bouncing segments.
        repeat (250) begin
            sw = 1'($urandom_range(0, 1));
            tick($urandom_range(1, 14));
        end
        sw = 1'b0;
        tick(20);

        // Reset while pressed: progress is discarded and the press is debounced again.
        sw = 1'b1;
        tick(12);
        check("pre_reset_switch", 32'(o_switch), 32'd1);
        do_reset(1);
        check("midrst_switch", 32'(o_switch), 32'd0);
        check("midrst_press", 32'(o_press), 32'd0);
        check("midrst_count", 32'(o_count), 32'd0);
        watch(12, p_at, l_at, r_at);
        check("midrst_press_edge", 32'(p_at), 32'd6);
        check("midrst_count_after", 32'(o_count), 32'd1);
        sw = 1'b0;
        tick(15);

        // Counter wrap: 256 clean press/release cycles from reset.
        do_reset(2);
        p0 = n_press_seen;
        for (int i = 0; i < 256; i++) begin
            sw = 1'b1;
            tick(10);
            sw = 1'b0;
            tick(10);
        end
        check("wrap_presses", 32'(n_press_seen - p0), 32'd256);
        check("wrap_count", 32'(o_count), 32'd0);
        check("wrap_queue_empty", 32'(exp_q.size()), 32'd0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
